// File: rtl/mac_row_drain.sv
`default_nettype none
//==============================================================================
// Module   : mac_row_drain
// Brief    : COL-lane MAC row with weight-stationary and output-stationary
//            modes. A drain FSM serially unloads the OS accumulators through
//            a valid/ready port, lowest lane first.
// Revision : 1.0 - initial release
//==============================================================================
module mac_row_drain #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int COL     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     os_mode,
  input  logic [BW-1:0]            in_w,
  input  logic [1:0]               inst_w,
  input  logic [PSUM_BW*COL-1:0]   in_n,
  output logic [PSUM_BW*COL-1:0]   out_s,
  output logic [COL-1:0]           valid,
  input  logic                     flush,
  output logic [PSUM_BW-1:0]       drain_data,
  output logic [$clog2(COL)-1:0]   drain_col,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic                     busy
);

  localparam int               PTR_W      = $clog2(COL);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(COL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_drain_valid;
  logic [PTR_W-1:0]         r_ptr;
  logic                     r_os_hold;

  logic                     w_os;
  logic                     w_hs;
  logic                     w_clear_wt;
  logic [PSUM_BW*COL-1:0]   w_acc_flat;
  logic [BW*(COL-1)-1:0]    w_fwd_a;
  logic [2*(COL-1)-1:0]     w_fwd_inst;

  // Mode is frozen for the whole drain/clear so a mid-drain toggle cannot
  // reinterpret tokens that are still travelling down the row.
  assign w_os       = r_busy ? r_os_hold : os_mode;
  assign w_hs       = r_drain_valid & drain_ready;
  assign w_clear_wt = (r_state == S_CLEAR);

  assign busy        = r_busy;
  assign drain_valid = r_drain_valid;
  assign drain_col   = r_ptr;
  // Accumulator of the pointed lane; no in-flight token can still target it
  // once it is presented, so the word is stable while the consumer stalls.
  assign drain_data  = r_drain_valid ? w_acc_flat[r_ptr*PSUM_BW +: PSUM_BW] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < COL; gi++) begin : g_lane
      logic [BW-1:0]      w_a;
      logic [1:0]         w_inst;
      logic [PSUM_BW-1:0] w_n;
      logic [BW-1:0]      w_mul_b;
      logic [PSUM_BW-1:0] w_a_x;
      logic [PSUM_BW-1:0] w_b_x;
      logic [PSUM_BW-1:0] w_prod;
      logic               w_exec;
      logic               w_capture;
      logic               w_drain_clr;
      logic               w_acc_exec;

      logic               r_loaded;
      logic [BW-1:0]      r_weight;
      logic [PSUM_BW-1:0] r_acc;
      logic [PSUM_BW-1:0] r_out;
      logic               r_valid;

      if (gi == 0) begin : g_head
        // New instructions are blocked at the row entrance while busy.
        assign w_a    = in_w;
        assign w_inst = r_busy ? 2'b00 : inst_w;
      end else begin : g_body
        assign w_a    = w_fwd_a[(gi-1)*BW +: BW];
        assign w_inst = w_fwd_inst[(gi-1)*2 +: 2];
      end

      assign w_n         = in_n[gi*PSUM_BW +: PSUM_BW];
      assign w_exec      = w_inst[1];
      assign w_capture   = ~w_os & w_inst[0] & ~r_loaded & ~w_clear_wt;
      assign w_drain_clr = w_hs & (r_ptr == PTR_W'(gi));
      assign w_acc_exec  = w_os & w_exec;

      // Sign-extending both operands to PSUM_BW gives the wrapped signed product.
      assign w_mul_b = w_os ? w_n[BW-1:0] : r_weight;
      assign w_a_x   = {{(PSUM_BW-BW){w_a[BW-1]}}, w_a};
      assign w_b_x   = {{(PSUM_BW-BW){w_mul_b[BW-1]}}, w_mul_b};
      assign w_prod  = w_a_x * w_b_x;

      // Per-lane weight capture, accumulator, south output and valid.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_loaded <= 1'b0;
          r_weight <= '0;
          r_acc    <= '0;
          r_out    <= '0;
          r_valid  <= 1'b0;
        end else begin
          r_valid <= w_exec;
          if (w_clear_wt) begin
            r_loaded <= 1'b0;
            r_weight <= '0;
          end else if (w_capture) begin
            r_loaded <= 1'b1;
            r_weight <= w_a;
          end
          // A drained lane restarts from zero, even if a token lands together.
          if (w_drain_clr || w_acc_exec) begin
            r_acc <= (w_drain_clr ? '0 : r_acc) + (w_acc_exec ? w_prod : '0);
          end
          if (w_os) begin
            r_out <= w_n;
          end else if (w_exec) begin
            r_out <= w_n + w_prod;
          end
        end
      end

      if (gi < COL - 1) begin : g_fwd
        logic [BW-1:0] r_fa;
        logic [1:0]    r_finst;

        // Forward activation and instruction east; a consumed load token stops here.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_fa    <= '0;
            r_finst <= 2'b00;
          end else begin
            r_fa    <= w_a;
            r_finst <= {w_inst[1], w_inst[0] & ~w_capture};
          end
        end

        assign w_fwd_a[gi*BW +: BW]  = r_fa;
        assign w_fwd_inst[gi*2 +: 2] = r_finst;
      end

      assign w_acc_flat[gi*PSUM_BW +: PSUM_BW] = r_acc;
      assign out_s[gi*PSUM_BW +: PSUM_BW]      = r_out;
      assign valid[gi]                         = r_valid;
    end
  endgenerate

  // Control FSM: flush starts a serial drain (OS) or a one-cycle weight clear (WS).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_drain_valid <= 1'b0;
      r_ptr         <= '0;
      r_os_hold     <= 1'b0;
    end else begin
      r_os_hold <= w_os;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_busy <= 1'b1;
            if (w_os) begin
              r_state       <= S_DRAIN;
              r_drain_valid <= 1'b1;
              r_ptr         <= '0;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (r_ptr == C_LAST_PTR) begin
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
              r_drain_valid <= 1'b0;
              r_ptr         <= '0;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_drain_valid <= 1'b0;
          r_ptr         <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
